tff_toggle_arbiter: RTL and testbench

Round-robin arbiter sharing a bank of WIDTH T flip-flops between NREQ requesters. Each requester asks to toggle one bit by index. The block grants one request at a time and drives a single-cycle one-hot t_vec pulse into the bank's t inputs. A programmable cooldown follows each pulse, so bank outputs settle before the next toggle.

---
 rtl/tff_toggle_arbiter.sv | 148 ++++++++++++++
 tb/tb_tff_toggle_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_arbiter.sv
// ---------------------------------------------------------------------------
// tff_toggle_arbiter
//
// Round-robin arbiter that shares one bank of WIDTH T flip-flops between NREQ
// requesters. Each requester asks for one bit to be toggled, named by an index.
// One request is granted at a time. The grant drives a single-cycle one-hot
// pulse on t_vec, which feeds the t inputs of the bank. After every grant the
// block stays busy for COOL cycles so the bank outputs settle before the next
// toggle.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low (0 = reset)
//   req        - per-requester toggle request (level, held until granted)
//   req_idx    - packed bit indices; requester i uses [i*IDXW +: IDXW]
//   gnt        - one-hot grant, one-cycle pulse
//   t_vec      - one-hot toggle pulse to the bank t inputs
//   err        - one-cycle pulse when the granted index is >= WIDTH
//   busy       - high whenever the arbiter is not idle
//   toggle_cnt - number of t pulses issued (wraps at 16 bits)
// ---------------------------------------------------------------------------
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int COOL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     t_vec,
    output logic                 err,
    output logic                 busy,
    output logic [15:0]          toggle_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] COOL_LOAD = (COOL > 0) ? 4'(COOL - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic             found;
    logic [IDXW-1:0]  win_idx;
    logic             idx_ok;
    logic [3:0]       cool_cnt;

    logic [NREQ-1:0]  gnt_next;
    logic [WIDTH-1:0] t_vec_next;
    logic             err_next;

    // Round-robin scan starting at ptr; the first set request wins.
    always_comb begin
        logic [PW-1:0] pos;
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = PW'((int'(ptr) + off) % NREQ);
            if (!found && req[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    // Index of the winning requester and whether it addresses a real bit.
    assign win_idx = req_idx[winner*IDXW +: IDXW];
    assign idx_ok  = (int'(win_idx) < WIDTH);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. WAIT is skipped entirely when there is no cooldown.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = GRANT;
            GRANT:   state_next = (COOL > 0) ? WAIT : IDLE;
            WAIT:    if (cool_cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values for the GRANT cycle. These are computed at the arbitration
    // edge and registered, so gnt/t_vec/err appear exactly in the GRANT cycle.
    always_comb begin
        gnt_next   = '0;
        t_vec_next = '0;
        err_next   = 1'b0;
        if (state == IDLE && found) begin
            gnt_next = NREQ'(1) << winner;
            if (idx_ok) begin
                t_vec_next = WIDTH'(1) << win_idx;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // Registered outputs, pointer and cooldown counter. The pointer moves past
    // the winner at the arbitration edge. Arbitration only happens in IDLE, so
    // this is indistinguishable from moving it during GRANT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt        <= '0;
            t_vec      <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            toggle_cnt <= 16'd0;
            ptr        <= '0;
            cool_cnt   <= 4'd0;
        end else begin
            gnt   <= gnt_next;
            t_vec <= t_vec_next;
            err   <= err_next;
            busy  <= (state_next != IDLE);
            if (|t_vec_next) begin
                toggle_cnt <= toggle_cnt + 16'd1;
            end
            if (state == IDLE && found) begin
                ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
            end
            if (state == GRANT) begin
                cool_cnt <= COOL_LOAD;
            end else if (state == WAIT && cool_cnt != 4'd0) begin
                cool_cnt <= cool_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tff_toggle_arbiter
//
// Self-checking bench for tff_toggle_arbiter. The bench has two instances that
// share all inputs. One has WIDTH=8 and the other WIDTH=6, so out-of-range
// indices can be exercised. Both instances use NREQ=4, IDXW=3 and COOL=2.
// A timeline model predicts every output on every cycle. Directed sequences
// pin the model with hand-computed values. A randomized phase then drives
// requesters that follow the request/grant handshake.
// ---------------------------------------------------------------------------
module tb_tff_toggle_arbiter;

    localparam int NREQ = 4;
    localparam int IDXW = 3;
    localparam int COOL = 2;
    localparam int W0   = 8;
    localparam int W1   = 6;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;

    logic [NREQ-1:0] gnt8,  gnt6;
    logic [W0-1:0]   t_vec8;
    logic [W1-1:0]   t_vec6;
    logic            err8,  err6;
    logic            busy8, busy6;
    logic [15:0]     cnt8,  cnt6;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_on    = 1'b0;

    // Model state per instance (0: WIDTH=8, 1: WIDTH=6).
    // left = cycles until the arbiter can accept a new request.
    int              mdl_left [2];
    int              mdl_ptr  [2];
    logic [15:0]     mdl_cnt  [2];
    logic [NREQ-1:0] mdl_gnt  [2];
    logic [7:0]      mdl_tvec [2];
    logic            mdl_err  [2];

    tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(W0), .IDXW(IDXW), .COOL(COOL)) dut8 (
        .clk(clk), .rst(rst), .req(req), .req_idx(req_idx),
        .gnt(gnt8), .t_vec(t_vec8), .err(err8), .busy(busy8), .toggle_cnt(cnt8)
    );

    tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(W1), .IDXW(IDXW), .COOL(COOL)) dut6 (
        .clk(clk), .rst(rst), .req(req), .req_idx(req_idx),
        .gnt(gnt6), .t_vec(t_vec6), .err(err6), .busy(busy6), .toggle_cnt(cnt6)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin choice: the first requester at or after p, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic int idx_of(input logic [NREQ*IDXW-1:0] ix, input int w);
        return int'(ix[w*IDXW +: IDXW]);
    endfunction

    function automatic int width_of(input int m);
        return (m == 0) ? W0 : W1;
    endfunction

    // Timeline model. Whenever the arbiter is free and someone requests, it
    // grants the round-robin winner for exactly one cycle. It is then
    // unavailable for 1 + COOL cycles, the grant cycle plus the cooldown.
    always @(posedge clk or negedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                mdl_left[m] <= 0;
                mdl_ptr[m]  <= 0;
                mdl_cnt[m]  <= 16'd0;
                mdl_gnt[m]  <= '0;
                mdl_tvec[m] <= 8'd0;
                mdl_err[m]  <= 1'b0;
            end else if (mdl_left[m] == 0 && req != '0) begin
                mdl_gnt[m]  <= NREQ'(1 << rr_pick(req, mdl_ptr[m]));
                mdl_ptr[m]  <= (rr_pick(req, mdl_ptr[m]) + 1) % NREQ;
                mdl_left[m] <= 1 + COOL;
                if (idx_of(req_idx, rr_pick(req, mdl_ptr[m])) < width_of(m)) begin
                    mdl_tvec[m] <= 8'(1 << idx_of(req_idx, rr_pick(req, mdl_ptr[m])));
                    mdl_err[m]  <= 1'b0;
                    mdl_cnt[m]  <= mdl_cnt[m] + 16'd1;
                end else begin
                    mdl_tvec[m] <= 8'd0;
                    mdl_err[m]  <= 1'b1;
                end
            end else begin
                mdl_gnt[m]  <= '0;
                mdl_tvec[m] <= 8'd0;
                mdl_err[m]  <= 1'b0;
                if (mdl_left[m] > 0) mdl_left[m] <= mdl_left[m] - 1;
            end
        end
    end

    // Single comparison point: counts the check and reports a failure.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge, compare both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("gnt8",  32'(gnt8),   32'(mdl_gnt[0]));
            checkOutput("tvec8", 32'(t_vec8), 32'(mdl_tvec[0]));
            checkOutput("err8",  32'(err8),   32'(mdl_err[0]));
            checkOutput("busy8", 32'(busy8),  32'(mdl_left[0] > 0));
            checkOutput("cnt8",  32'(cnt8),   32'(mdl_cnt[0]));
            checkOutput("gnt6",  32'(gnt6),   32'(mdl_gnt[1]));
            checkOutput("tvec6", 32'(t_vec6), 32'(mdl_tvec[1]));
            checkOutput("err6",  32'(err6),   32'(mdl_err[1]));
            checkOutput("busy6", 32'(busy6),  32'(mdl_left[1] > 0));
            checkOutput("cnt6",  32'(cnt6),   32'(mdl_cnt[1]));
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*IDXW-1:0] ix);
        req     = r;
        req_idx = ix;
    endtask

    // Reset for two cycles, released on a falling edge with requests cleared.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Directed sequences with hand-computed expectations, then random traffic.
    initial begin
        rst     = 1'b0;
        req     = 4'b1111;
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};

        // Reset held with all requests pending and the clock running.
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        checkOutput("rst_gnt",  32'(gnt8),   32'h0);
        checkOutput("rst_tvec", 32'(t_vec8), 32'h0);
        checkOutput("rst_busy", 32'(busy8),  32'h0);
        checkOutput("rst_cnt",  32'(cnt8),   32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rel_gnt", 32'(gnt8), 32'h1);

        // Single request with idx 5: the t pulse is 0x20, then COOL busy cycles.
        doReset();
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
        @(negedge clk);
        checkOutput("one_gnt",  32'(gnt8),   32'h1);
        checkOutput("one_tvec", 32'(t_vec8), 32'h20);
        checkOutput("one_cnt",  32'(cnt8),   32'd1);
        req = '0;
        @(negedge clk);
        checkOutput("one_busy2", 32'(busy8), 32'h1);
        @(negedge clk);
        checkOutput("one_busy3", 32'(busy8), 32'h1);
        @(negedge clk);
        checkOutput("one_busy4", 32'(busy8), 32'h0);

        // All four requesters at once, each dropping after its grant.
        doReset();
        applyStimulus(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if ((n - 1) % 4 == 0) begin
                checkOutput("all_gnt",  32'(gnt8),   32'(1 << ((n - 1) / 4)));
                checkOutput("all_tvec", 32'(t_vec8), 32'(1 << ((n - 1) / 4)));
                req[(n - 1) / 4] = 1'b0;
            end
        end
        checkOutput("all_cnt", 32'(cnt8), 32'd4);

        // Fairness: requesters 0 and 2 held continuously alternate.
        doReset();
        applyStimulus(4'b0101, {3'd0, 3'd6, 3'd0, 3'd1});
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            if ((n - 1) % 4 == 0) begin
                checkOutput("fair_gnt",  32'(gnt8),   (((n - 1) / 4) % 2 == 0) ? 32'h1 : 32'h4);
                checkOutput("fair_tvec", 32'(t_vec8), (((n - 1) / 4) % 2 == 0) ? 32'h02 : 32'h40);
            end
        end

        // Asynchronous reset in the middle of a GRANT cycle. Requester 2 wins
        // first, which moves the pointer to 3. After reset the scan must start
        // at 0 again, so requester 1 beats requester 3.
        doReset();
        applyStimulus(4'b0100, {3'd0, 3'd2, 3'd0, 3'd0});
        @(negedge clk);
        checkOutput("mid_gnt_pre", 32'(gnt8), 32'h4);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_gnt_cut",  32'(gnt8),   32'h0);
        checkOutput("mid_tvec_cut", 32'(t_vec8), 32'h0);
        checkOutput("mid_busy_cut", 32'(busy8),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'b1010, {3'd4, 3'd0, 3'd3, 3'd0});
        @(negedge clk);
        checkOutput("mid_gnt_post",  32'(gnt8),   32'h2);
        checkOutput("mid_tvec_post", 32'(t_vec8), 32'h08);
        req = '0;

        // Index 7 is out of range for the WIDTH=6 instance.
        doReset();
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'd7});
        @(negedge clk);
        checkOutput("oor_gnt6",  32'(gnt6),   32'h1);
        checkOutput("oor_tvec6", 32'(t_vec6), 32'h0);
        checkOutput("oor_err6",  32'(err6),   32'h1);
        checkOutput("oor_cnt6",  32'(cnt6),   32'h0);
        checkOutput("oor_tvec8", 32'(t_vec8), 32'h80);
        req = '0;
        @(negedge clk);
        checkOutput("oor_err6_off", 32'(err6),  32'h0);
        checkOutput("oor_busy6_w1", 32'(busy6), 32'h1);
        @(negedge clk);
        checkOutput("oor_busy6_w2", 32'(busy6), 32'h1);
        @(negedge clk);
        checkOutput("oor_busy6_id", 32'(busy6), 32'h0);
        checkOutput("oor_cnt6_end", 32'(cnt6),  32'h0);

        // Random requesters following the handshake. After a grant a requester
        // either drops or re-requests with a new index. Occasionally it
        // withdraws before being granted. One reset is applied mid-run.
        doReset();
        for (int it = 0; it < 800; it++) begin
            @(negedge clk);
            if (it == 300) rst = 1'b0;
            if (it == 302) rst = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && mdl_gnt[0][i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else req_idx[i*IDXW +: IDXW] = 3'($urandom_range(7, 0));
                end else if (req[i]) begin
                    if ($urandom_range(24, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    req_idx[i*IDXW +: IDXW] = 3'($urandom_range(7, 0));
                end
            end
        end

        req = '0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
